// File: rtl/fb_scanout.sv
// 160x120x3 frame buffer with 4x4 pixel replication for VGA scanout, a
// valid/ready pixel write port and a full-buffer clear engine.
module fb_scanout #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2
) (
  input  logic       clk25MHz,
  input  logic       rst,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_active,
  output logic [2:0] o_rgb,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [7:0] i_wr_x,
  input  logic [6:0] i_wr_y,
  input  logic [2:0] i_wr_rgb,
  output logic       o_wr_err,
  input  logic       i_clear,
  input  logic [2:0] i_clear_rgb,
  output logic       o_busy
);

  localparam int DEPTH = FB_W * FB_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int SCR_W = FB_W << SCALE_LOG2;
  localparam int SCR_H = FB_H << SCALE_LOG2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t          r_state, w_state_nx;
  logic [AW-1:0]   r_clr_addr, w_clr_addr_nx;
  logic [2:0]      r_clr_rgb, w_clr_rgb_nx;
  logic            r_wr_ready, w_wr_ready_nx;
  logic            r_wr_err, w_wr_err_nx;
  logic            r_we, w_we_nx;
  logic [AW-1:0]   r_waddr, w_waddr_nx;
  logic [2:0]      r_wdata, w_wdata_nx;

  logic [2:0]      r_mem [DEPTH];
  logic [2:0]      r_ram_q;
  logic            r_gate;
  logic [2:0]      r_rgb;

  // Scanout address: row*160 as (row<<7)+(row<<5), fixed to the 160-wide layout.
  logic [AW-1:0]   w_rd_row, w_rd_col, w_rd_addr;
  logic            w_gate;

  assign w_rd_row  = AW'(i_y >> SCALE_LOG2);
  assign w_rd_col  = AW'(i_x >> SCALE_LOG2);
  assign w_gate    = i_active && (i_x < 10'(SCR_W)) && (i_y < 10'(SCR_H));
  // Blanked coordinates read address 0 so the RAM index never leaves range.
  assign w_rd_addr = w_gate ? ((w_rd_row << 7) + (w_rd_row << 5) + w_rd_col) : '0;

  logic [AW-1:0]   w_wr_row, w_wr_col, w_wr_addr;
  logic            w_wr_inrange, w_xfer;

  assign w_wr_row     = AW'(i_wr_y);
  assign w_wr_col     = AW'(i_wr_x);
  assign w_wr_addr    = (w_wr_row << 7) + (w_wr_row << 5) + w_wr_col;
  assign w_wr_inrange = (i_wr_x < 8'(FB_W)) && (i_wr_y < 7'(FB_H));
  assign w_xfer       = i_wr_valid && r_wr_ready;

  // Both the clear engine and the write port feed one registered write
  // request, so a write accepted with i_clear lands before clear address 0.
  always_comb begin
    w_state_nx    = r_state;
    w_clr_addr_nx = r_clr_addr;
    w_clr_rgb_nx  = r_clr_rgb;
    w_we_nx       = 1'b0;
    w_waddr_nx    = r_waddr;
    w_wdata_nx    = r_wdata;
    w_wr_err_nx   = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_we_nx    = 1'b1;
        w_waddr_nx = r_clr_addr;
        w_wdata_nx = r_clr_rgb;
        if (r_clr_addr == LAST_ADDR) w_state_nx = S_IDLE;
        else                         w_clr_addr_nx = r_clr_addr + 1'b1;
      end
      S_IDLE: begin
        if (w_xfer) begin
          if (w_wr_inrange) begin
            w_we_nx    = 1'b1;
            w_waddr_nx = w_wr_addr;
            w_wdata_nx = i_wr_rgb;
          end else begin
            w_wr_err_nx = 1'b1;
          end
        end
        if (i_clear) begin
          w_state_nx    = S_CLEAR;
          w_clr_addr_nx = '0;
          w_clr_rgb_nx  = i_clear_rgb;
        end
      end
      default: w_state_nx = S_CLEAR;
    endcase
    w_wr_ready_nx = (w_state_nx == S_IDLE);
  end

  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_clr_rgb  <= 3'b000;
      r_wr_ready <= 1'b0;
      r_wr_err   <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= 3'b000;
      r_gate     <= 1'b0;
      r_rgb      <= 3'b000;
    end else begin
      r_state    <= w_state_nx;
      r_clr_addr <= w_clr_addr_nx;
      r_clr_rgb  <= w_clr_rgb_nx;
      r_wr_ready <= w_wr_ready_nx;
      r_wr_err   <= w_wr_err_nx;
      r_we       <= w_we_nx;
      r_waddr    <= w_waddr_nx;
      r_wdata    <= w_wdata_nx;
      r_gate     <= w_gate;
      r_rgb      <= r_gate ? r_ram_q : 3'b000;
    end
  end

  // Simple dual-port RAM, read-first; a pending write is dropped by reset.
  always_ff @(posedge clk25MHz) begin
    if (r_we && !rst) r_mem[r_waddr] <= r_wdata;
    r_ram_q <= r_mem[w_rd_addr];
  end

  assign o_rgb      = r_rgb;
  assign o_wr_ready = r_wr_ready;
  assign o_wr_err   = r_wr_err;
  assign o_busy     = (r_state == S_CLEAR);

endmodule

// File: tb/tb_fb_scanout.sv
// Randomised scoreboard bench for fb_scanout: driver pushes expectations from a
// pixel-array model, a negedge monitor pops and compares them when due.
module tb_fb_scanout;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] i_x, i_y;
  logic       i_active;
  logic [2:0] o_rgb;
  logic       i_wr_valid, o_wr_ready;
  logic [7:0] i_wr_x;
  logic [6:0] i_wr_y;
  logic [2:0] i_wr_rgb;
  logic       o_wr_err;
  logic       i_clear;
  logic [2:0] i_clear_rgb;
  logic       o_busy;

  fb_scanout dut (
    .clk25MHz(clk), .rst(rst),
    .i_x(i_x), .i_y(i_y), .i_active(i_active), .o_rgb(o_rgb),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_x(i_wr_x), .i_wr_y(i_wr_y), .i_wr_rgb(i_wr_rgb), .o_wr_err(o_wr_err),
    .i_clear(i_clear), .i_clear_rgb(i_clear_rgb), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [2:0] exp;
    string      nm;
  } exp_t;

  exp_t       rd_q[$];
  exp_t       err_q[$];
  logic [2:0] model [19200];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] ref_px(input int x, input int y, input bit act);
    if (!act || x >= 640 || y >= 480) return 3'b000;
    return model[(y / 4) * 160 + x / 4];
  endfunction

  task automatic fill_model(input logic [2:0] c);
    for (int i = 0; i < 19200; i++) model[i] = c;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compare each expectation in the cycle it falls due.
  always @(negedge clk) begin
    exp_t e;
    while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      e = rd_q.pop_front();
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("FAIL %s: read missed, due %0d now %0d", e.nm, e.due, cyc);
      end else if (o_rgb !== e.exp) begin
        errors++;
        $display("FAIL %s: o_rgb got %b expected %b (cycle %0d)", e.nm, o_rgb, e.exp, cyc);
      end
    end
    while (err_q.size() > 0 && err_q[0].due <= cyc) begin
      e = err_q.pop_front();
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("FAIL %s: err check missed, due %0d now %0d", e.nm, e.due, cyc);
      end else if (o_wr_err !== e.exp[0]) begin
        errors++;
        $display("FAIL %s: o_wr_err got %b expected %b (cycle %0d)", e.nm, o_wr_err, e.exp[0], cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
    i_active = 1'b0;
  endtask

  task automatic drive_rd(input int x, input int y, input bit act, input string nm);
    exp_t e;
    @(posedge clk); #1;
    i_x = x[9:0]; i_y = y[9:0]; i_active = act;
    e.due = cyc + 2; e.exp = ref_px(x, y, act); e.nm = nm;
    rd_q.push_back(e);
  endtask

  task automatic rand_reads(input int n, input string nm);
    for (int i = 0; i < n; i++)
      drive_rd($urandom_range(799, 0), $urandom_range(524, 0), $urandom_range(7, 0) != 0, nm);
    idle(1);
  endtask

  task automatic drive_wr(input int x, input int y, input logic [2:0] c, input string nm);
    exp_t e;
    @(posedge clk); #1;
    chk({nm, "_ready"}, 32'(o_wr_ready), 32'd1);
    i_wr_valid = 1'b1; i_wr_x = x[7:0]; i_wr_y = y[6:0]; i_wr_rgb = c;
    e.due = cyc + 1; e.exp = {2'b00, !(x < 160 && y < 120)}; e.nm = nm;
    err_q.push_back(e);
    if (x < 160 && y < 120) model[y * 160 + x] = c;
  endtask

  task automatic wr_end();
    @(posedge clk); #1;
    i_wr_valid = 1'b0;
  endtask

  // Counts negedges with o_busy high; optionally re-requests a clear mid-way.
  task automatic measure_busy(input string nm, input bit mid_clear);
    int n;
    n = 0;
    for (int k = 0; k < 25000; k++) begin
      @(negedge clk);
      i_clear = 1'b0;
      if (o_busy !== 1'b1) break;
      n++;
      if (mid_clear && n == 5000) begin
        i_clear = 1'b1; i_clear_rgb = 3'b111;
      end
    end
    chk({nm, "_busy_len"}, 32'(n), 32'd19200);
    chk({nm, "_ready_after"}, 32'(o_wr_ready), 32'd1);
  endtask

  task automatic reset_checks(input string nm);
    @(negedge clk);
    chk({nm, "_busy"}, 32'(o_busy), 32'd1);
    chk({nm, "_ready"}, 32'(o_wr_ready), 32'd0);
    chk({nm, "_err"}, 32'(o_wr_err), 32'd0);
    chk({nm, "_rgb"}, 32'(o_rgb), 32'd0);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; i_x = '0; i_y = '0; i_active = 1'b0;
    i_wr_valid = 1'b0; i_wr_x = '0; i_wr_y = '0; i_wr_rgb = '0;
    i_clear = 1'b0; i_clear_rgb = '0;
    repeat (2) @(posedge clk);
    reset_checks("rst0");
    @(posedge clk); #1; rst = 1'b0;
    measure_busy("init", 1'b0);
    fill_model(3'b000);
    rand_reads(1500, "scan0");

    // Single pixel replication
    drive_wr(10, 20, 3'b101, "wr10_20");
    wr_end(); idle(3);
    for (int y = 76; y < 88; y++)
      for (int x = 36; x < 48; x++) drive_rd(x, y, 1'b1, "blk10_20");
    idle(1);

    // Commit timing: read on transfer edge and commit edge sees old data
    @(posedge clk); #1;
    i_wr_valid = 1'b1; i_wr_x = 8'd50; i_wr_y = 7'd60; i_wr_rgb = 3'b110;
    i_x = 10'd200; i_y = 10'd240; i_active = 1'b1;
    e.due = cyc + 2; e.exp = ref_px(200, 240, 1'b1); e.nm = "rd_xfer_edge"; rd_q.push_back(e);
    e.due = cyc + 1; e.exp = 3'b000; e.nm = "wr_ok_err"; err_q.push_back(e);
    @(posedge clk); #1;
    i_wr_valid = 1'b0;
    e.due = cyc + 2; e.exp = ref_px(201, 241, 1'b1); e.nm = "rd_commit_edge"; rd_q.push_back(e);
    i_x = 10'd201; i_y = 10'd241;
    model[60 * 160 + 50] = 3'b110;
    drive_rd(203, 243, 1'b1, "rd_after_commit");
    idle(3);

    // Out-of-range writes, back to back, must not alias into row 6
    drive_wr(0, 6, 3'b011, "wr0_6");
    drive_wr(160, 5, 3'b100, "bad160_5");
    drive_wr(200, 100, 3'b111, "bad200_100");
    drive_wr(3, 125, 3'b001, "bad3_125");
    drive_wr(1, 6, 3'b010, "wr1_6");
    wr_end(); idle(3);
    drive_rd(0, 24, 1'b1, "keep0_6");
    drive_rd(3, 27, 1'b1, "keep0_6b");
    drive_rd(4, 24, 1'b1, "px1_6");
    drive_rd(0, 20, 1'b1, "px0_5");
    idle(1);

    for (int i = 0; i < 120; i++)
      drive_wr($urandom_range(170, 0), $urandom_range(127, 0), 3'($urandom_range(7, 0)), "rndwr");
    wr_end(); idle(3);
    rand_reads(1500, "rndrd");

    // Blanking gate over written data
    drive_wr(10, 20, 3'b101, "wr10_20b");
    wr_end(); idle(3);
    drive_rd(40, 80, 1'b0, "gate_inactive");
    drive_rd(700, 80, 1'b1, "gate_x700");
    drive_rd(40, 500, 1'b1, "gate_y500");
    drive_rd(40, 80, 1'b1, "gate_open");
    idle(3);

    // Clear to 010 with an ignored second request mid-clear
    @(posedge clk); #1; i_clear = 1'b1; i_clear_rgb = 3'b010;
    @(posedge clk); #1; i_clear = 1'b0;
    chk("clr_ready_drop", 32'(o_wr_ready), 32'd0);
    measure_busy("clr010", 1'b1);
    fill_model(3'b010);
    rand_reads(1000, "scan010");

    // Reset at clear cycle 5000 restarts the clear with colour 0
    @(posedge clk); #1; i_clear = 1'b1; i_clear_rgb = 3'b101;
    @(posedge clk); #1; i_clear = 1'b0;
    repeat (5000) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk);
    reset_checks("rst1");
    @(posedge clk); #1; rst = 1'b0;
    measure_busy("rstclr", 1'b0);
    fill_model(3'b000);
    rand_reads(500, "scanrst");

    idle(4);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("err_q_drained", 32'(err_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
